// File: rtl/sw_conditioner.sv
// Multi-channel switch conditioner: sync, debounce, polarity fix, edge pulses, heartbeat.
// Define SW_CONDITIONER_HOLD_EN to build the per-channel long-press (hold_o) logic.
module sw_conditioner #(
  parameter int            CH           = 4,
  parameter int            DEBOUNCE_CYC = 1_000_000,
  parameter int            HB_CYC       = 10_000_000,
  parameter int            HOLD_CYC     = 50_000_000,
  parameter logic [CH-1:0] INV_MASK     = {CH{1'b0}}
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic [CH-1:0] raw_i,
  output logic [CH-1:0] level_o,
  output logic [CH-1:0] rise_o,
  output logic [CH-1:0] fall_o,
  output logic [CH-1:0] hold_o,
  output logic          any_edge_o,
  output logic          heartbeat_o
);

  localparam int DW  = $clog2(DEBOUNCE_CYC + 1);
  localparam int HBW = $clog2(HB_CYC + 1);
  localparam logic [DW-1:0]  DB_TERM = DW'(DEBOUNCE_CYC - 1);
  localparam logic [HBW-1:0] HB_TERM = HBW'(HB_CYC - 1);

  if (CH < 1 || CH > 32 || DEBOUNCE_CYC < 1 || HB_CYC < 1 || HOLD_CYC < 1) begin : g_param_err
    $error("sw_conditioner: parameter out of range");
  end

  logic [CH-1:0]  sync1_q, sync2_q;
  logic [CH-1:0]  level_q, level_d;
  logic [CH-1:0]  rise_q, rise_d, fall_q, fall_d;
  logic [DW-1:0]  dcnt_q [CH];
  logic [DW-1:0]  dcnt_d [CH];
  logic [HBW-1:0] hb_cnt_q, hb_cnt_d;
  logic           hb_q, hb_d;

  // Level only follows sync after DEBOUNCE_CYC consecutive differing samples.
  always_comb begin
    level_d = level_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int n = 0; n < CH; n++) begin
      dcnt_d[n] = '0;
      if (sync2_q[n] != level_q[n]) begin
        if (dcnt_q[n] == DB_TERM) begin
          level_d[n] = sync2_q[n];
          rise_d[n]  = sync2_q[n];
          fall_d[n]  = ~sync2_q[n];
        end else begin
          dcnt_d[n] = dcnt_q[n] + DW'(1);
        end
      end
    end
  end

  always_comb begin
    hb_cnt_d = hb_cnt_q + HBW'(1);
    hb_d     = hb_q;
    if (hb_cnt_q == HB_TERM) begin
      hb_cnt_d = '0;
      hb_d     = ~hb_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      level_q  <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      hb_cnt_q <= '0;
      hb_q     <= 1'b0;
      for (int n = 0; n < CH; n++) dcnt_q[n] <= '0;
    end else begin
      sync1_q  <= raw_i ^ INV_MASK;
      sync2_q  <= sync1_q;
      level_q  <= level_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      hb_cnt_q <= hb_cnt_d;
      hb_q     <= hb_d;
      for (int n = 0; n < CH; n++) dcnt_q[n] <= dcnt_d[n];
    end
  end

`ifdef SW_CONDITIONER_HOLD_EN
  localparam int HW = $clog2(HOLD_CYC + 1);
  localparam logic [HW-1:0] HOLD_TERM = HW'(HOLD_CYC);

  logic [HW-1:0] hcnt_q [CH];
  logic [HW-1:0] hcnt_d [CH];
  logic [CH-1:0] hold_q, hold_d;

  // Clearing on the next level lets hold drop in the same cycle as fall_o.
  always_comb begin
    hold_d = '0;
    for (int n = 0; n < CH; n++) begin
      hcnt_d[n] = hcnt_q[n];
      if (!level_d[n]) begin
        hcnt_d[n] = '0;
      end else if (level_q[n] && hcnt_q[n] != HOLD_TERM) begin
        hcnt_d[n] = hcnt_q[n] + HW'(1);
      end
      hold_d[n] = (hcnt_d[n] == HOLD_TERM);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hold_q <= '0;
      for (int n = 0; n < CH; n++) hcnt_q[n] <= '0;
    end else begin
      hold_q <= hold_d;
      for (int n = 0; n < CH; n++) hcnt_q[n] <= hcnt_d[n];
    end
  end

  assign hold_o = hold_q;
`else
  assign hold_o = {CH{1'b0}};
`endif

  assign level_o     = level_q;
  assign rise_o      = rise_q;
  assign fall_o      = fall_q;
  assign any_edge_o  = |(rise_q | fall_q);
  assign heartbeat_o = hb_q;

endmodule

// File: doc/sw_conditioner.md
# sw_conditioner

Parametrised multi-channel input conditioner for the board-control layer. It takes CH asynchronous push-button/switch inputs and, per channel, synchronises, debounces and polarity-corrects each one, then emits edge pulses and an optional long-press flag. A programmable heartbeat toggle is generated alongside, so CPU reset/start controls and status LEDs are all served from one block in the system clock domain.

## Interface
Parameters:
- CH, 4, number of input channels (1..32)
- DEBOUNCE_CYC, 1_000_000, cycles a synchronised input must stay stable before it is accepted (>=1; 20 ms at 50 MHz)
- HB_CYC, 10_000_000, heartbeat half-period in cycles (>=1)
- HOLD_CYC, 50_000_000, cycles level must stay high before hold asserts (>=1; used only with hold feature)
- INV_MASK, {CH{1'b0}}, bit n=1: channel n is active-low at the pin

Ports:
- clk_i  in  1  system clock; all logic on rising edge
- rst_n_i  in  1  reset, asynchronous assert, active-low
- raw_i  in  CH  raw pin inputs, asynchronous to clk_i
- level_o  out  CH  debounced, polarity-corrected level (1 = active)
- rise_o  out  CH  one-cycle pulse on level_o 0->1
- fall_o  out  CH  one-cycle pulse on level_o 1->0
- hold_o  out  CH  long-press flag
- any_edge_o  out  1  OR of rise_o | fall_o
- heartbeat_o  out  1  toggles every HB_CYC cycles

## Operation
- Per channel n: pin value XOR INV_MASK[n] -> 2-flop synchroniser -> debounce counter -> level register.
- Synchroniser flops reset to 0 (post-inversion inactive), so no edge is generated when an idle pin is released from reset.
- Debounce: counter width $clog2(DEBOUNCE_CYC+1). If sync == level: counter cleared to 0. If sync != level: counter increments; when counter == DEBOUNCE_CYC-1 and sync still != level, level takes sync and counter clears in the same cycle.
- Any bounce (sync returning to level before terminal count) clears the counter; the window restarts from zero on the next difference.
- rise_o/fall_o are registered and asserted in exactly the cycle level_o first shows the new value; never both high; never high two consecutive cycles on one channel.
- Hold: per-channel counter, width $clog2(HOLD_CYC+1), counts while level_o=1, saturates at HOLD_CYC; hold_o=1 when counter == HOLD_CYC; counter and hold_o clear in the cycle level_o goes to 0 (same cycle as fall_o).
- Heartbeat: counter 0..HB_CYC-1; at HB_CYC-1 counter wraps to 0 and heartbeat_o inverts.
- Channels fully independent; simultaneous edges on several channels all report in their own cycles.

## Timing
- Reset values (rst_n_i=0, immediate): level_o=0, rise_o=0, fall_o=0, hold_o=0, any_edge_o=0, heartbeat_o=0, all counters 0.
- Reset release mid-debounce or mid-hold: all progress is discarded; a pin held active through reset is reported as a fresh rise after full latency.
- Latency, clean pin step at edge k: sync valid at k+2; level_o, rise_o valid at k+2+DEBOUNCE_CYC.
- hold_o asserts HOLD_CYC cycles after the rise_o cycle.
- heartbeat_o first toggles HB_CYC cycles after reset release, then every HB_CYC cycles.
- any_edge_o is combinational OR of registered pulses (no extra latency).

## Configuration
- SW_CONDITIONER_HOLD_EN defined: hold counters and hold_o logic as above.
- Not defined: no hold counters synthesised; hold_o tied to {CH{1'b0}}; HOLD_CYC ignored. All other behaviour identical.

## Test plan
Bench parameters CH=4, DEBOUNCE_CYC=8, HB_CYC=5, HOLD_CYC=20, INV_MASK=4'b0010, macro defined unless stated.
- Reset, all raw_i idle (4'b0010) -> all outputs 0 after reset release; no rise/fall ever; heartbeat_o toggles at cycles 5, 10, 15.
- raw_i[0] 0->1 at edge k, held -> level_o[0]=1 and rise_o[0]=1 for exactly one cycle at k+10; any_edge_o=1 that cycle.
- raw_i[2] glitches high for 7 cycles, low 1 cycle, high 7 cycles -> no level change, no pulse; then held high -> rise at 10 cycles after last low.
- raw_i[1] driven 0 (active-low press) held 30 cycles -> rise_o[1] at +10, hold_o[1]=1 at rise+20; release -> fall_o[1] at +10 and hold_o[1] cleared same cycle.
- raw_i[0] and raw_i[3] press same edge; rst_n_i pulsed low at +5 -> outputs 0 immediately, no pulses; after release both rise 10 cycles later together. Rebuild without macro -> hold_o stays 4'b0000 throughout.
